// File: rtl/dmem_pkg.sv
// Shared types and constants for the darkriscv data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

    localparam logic [2:0] DLEN_BYTE = 3'd1;
    localparam logic [2:0] DLEN_HALF = 3'd2;
    localparam logic [2:0] DLEN_WORD = 3'd4;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_lane_decoder.sv
// Maps access size and low address bits to byte strobes, flagging bad
// alignment and unknown size codes.
module dmem_lane_decoder
    import dmem_pkg::*;
(
    input  logic [2:0] dlen,
    input  logic [1:0] addr_lo,
    output logic [3:0] be,
    output logic       misaligned,
    output logic       illegal
);

    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (dlen)
            DLEN_WORD: begin
                be         = 4'b1111;
                misaligned = |addr_lo;
            end
            DLEN_HALF: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
            end
            DLEN_BYTE: begin
                be         = 4'b0001 << addr_lo;
            end
            default: begin
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/darkriscv_dmem_responder.sv
// Terminates the darkriscv data bus in a local word RAM with wait states.
// Optional access counters are enabled by defining DMEM_ACCESS_COUNTERS_EN.
//
// state  | meaning
// IDLE   | waiting for das & (drd | dwr); stalls the core combinationally
// WAIT   | burning WAIT_STATES cycles on the latched request
// ACCESS | RAM read or byte-enabled write
// RESP   | datai/err valid, hlt released
module darkriscv_dmem_responder
    import dmem_pkg::*;
#(
    parameter int          MEMORY_SIZE = 4096,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        das,
    input  logic        drd,
    input  logic        dwr,
    input  logic [31:0] daddr,
    input  logic [31:0] datao,
    input  logic [2:0]  dlen,
    output logic [31:0] datai,
    output logic        hlt,
    output logic        err
`ifdef DMEM_ACCESS_COUNTERS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int WORDS = MEMORY_SIZE / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(MEMORY_SIZE);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    logic [31:0] mem [WORDS];

    dmem_state_t           state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  wr_q, wr_d;
    logic                  fault_q, fault_d;
    logic [31:0]           datai_q, datai_d;
    logic                  err_q, err_d;

    logic        req;
    logic [31:0] offset;
    logic        out_of_range;
    logic [3:0]  be_dec;
    logic        misaligned;
    logic        illegal;
    logic        fault_in;

    dmem_lane_decoder u_lane (
        .dlen       (dlen),
        .addr_lo    (daddr[1:0]),
        .be         (be_dec),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign req          = das & (drd | dwr);
    assign offset       = daddr - BASE_ADDR;
    assign out_of_range = (daddr < BASE_ADDR) || (offset >= MEM_BYTES);
    // A simultaneous read+write is carried out as a (dropped) faulting write.
    assign fault_in     = out_of_range | misaligned | illegal | (drd & dwr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            datai_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            fault_q <= fault_d;
            datai_q <= datai_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (cnt_q == '0) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        fault_d = fault_q;
        datai_d = datai_q;
        err_d   = 1'b0;
        if (state_q == IDLE && req) begin
            cnt_d   = WAIT_LOAD;
            idx_d   = offset[IDX_W+1:2];
            wdata_d = datao;
            be_d    = be_dec;
            wr_d    = dwr;
            fault_d = fault_in;
        end
        if (state_q == WAIT) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (state_q == ACCESS) begin
            err_d = fault_q;
            if (!wr_q) begin
                datai_d = fault_q ? 32'h0000_0000 : mem[idx_q];
            end
        end
    end

    // hlt is gated by reset so the core is released the moment reset asserts.
    always_comb begin
        hlt = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE:    hlt = req;
                WAIT:    hlt = 1'b1;
                ACCESS:  hlt = 1'b1;
                default: hlt = 1'b0;
            endcase
        end
    end

    assign datai = datai_q;
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (state_q == ACCESS && wr_q && !fault_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

`ifdef DMEM_ACCESS_COUNTERS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == RESP && !fault_q) begin
            if (wr_q) wr_count_d = wr_count_q + 32'd1;
            else      rd_count_d = rd_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_darkriscv_dmem_responder.sv
// Directed bench: one responder with one wait state at base 0, one with zero
// wait states at base 0x2000 (256 bytes), sharing the bus inputs.
module tb_darkriscv_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        das = 1'b0, drd = 1'b0, dwr = 1'b0;
    logic [31:0] daddr = '0, datao = '0;
    logic [2:0]  dlen = 3'd4;
    logic        sel = 1'b0;

    logic [31:0] datai0, datai1;
    logic        hlt0, hlt1, err0, err1;
`ifdef DMEM_ACCESS_COUNTERS_EN
    logic [31:0] rdc0, wrc0, rdc1, wrc1;
`endif

    logic [31:0] datai_m;
    logic        hlt_m, err_m;
    assign datai_m = sel ? datai1 : datai0;
    assign hlt_m   = sel ? hlt1 : hlt0;
    assign err_m   = sel ? err1 : err0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    darkriscv_dmem_responder #(
        .MEMORY_SIZE (4096),
        .WAIT_STATES (1),
        .BASE_ADDR   (32'h0000_0000)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .das   (das & ~sel),
        .drd   (drd),
        .dwr   (dwr),
        .daddr (daddr),
        .datao (datao),
        .dlen  (dlen),
        .datai (datai0),
        .hlt   (hlt0),
        .err   (err0)
`ifdef DMEM_ACCESS_COUNTERS_EN
        ,
        .rd_count (rdc0),
        .wr_count (wrc0)
`endif
    );

    darkriscv_dmem_responder #(
        .MEMORY_SIZE (256),
        .WAIT_STATES (0),
        .BASE_ADDR   (32'h0000_2000)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .das   (das & sel),
        .drd   (drd),
        .dwr   (dwr),
        .daddr (daddr),
        .datao (datao),
        .dlen  (dlen),
        .datai (datai1),
        .hlt   (hlt1),
        .err   (err1)
`ifdef DMEM_ACCESS_COUNTERS_EN
        ,
        .rd_count (rdc1),
        .wr_count (wrc1)
`endif
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request in an IDLE cycle, counts stall cycles until hlt drops,
    // then samples the response and returns in the cycle after RESP.
    int start_cyc;
    task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] len,
                        output int lat, output logic [31:0] rdata, output logic errp);
        @(negedge clk);
        start_cyc = cyc;
        das = 1'b1; drd = rd; dwr = wr; daddr = a; datao = d; dlen = len;
        #1;
        lat = 0;
        while (hlt_m && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = datai_m;
        errp  = err_m;
        das = 1'b0; drd = 1'b0; dwr = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        int          starts [4];
        logic [31:0] vals [4];

        repeat (3) @(negedge clk);
        check_vec("rst_hlt0", {31'b0, hlt0}, 32'd0);
        check_vec("rst_err0", {31'b0, err0}, 32'd0);
        check_vec("rst_datai0", datai0, 32'd0);
        check_vec("rst_datai1", datai1, 32'd0);
        reset = 1'b1;

        // one wait state: latency WAIT_STATES+2 = 3
        xact(0, 1, 32'h10, 32'hDEADBEEF, DLEN_WORD, lat, rd, e);
        check_vec("ww_lat", lat, 3);
        check_vec("ww_err", {31'b0, e}, 0);
        check_vec("ww_datai_hold", rd, 32'h0);
        xact(1, 0, 32'h10, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("wr_lat", lat, 3);
        check_vec("wr_data", rd, 32'hDEADBEEF);
        check_vec("wr_err", {31'b0, e}, 0);

        xact(0, 1, 32'h12, 32'h00AA0000, DLEN_BYTE, lat, rd, e);
        check_vec("bw_datai_hold", rd, 32'hDEADBEEF);
        check_vec("bw_err", {31'b0, e}, 0);
        xact(1, 0, 32'h10, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("bw_read", rd, 32'hDEAABEEF);

        xact(0, 1, 32'h12, 32'h12340000, DLEN_HALF, lat, rd, e);
        xact(1, 0, 32'h10, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("hw_read", rd, 32'h1234BEEF);

        xact(1, 0, 32'h11, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("mis_rd_err", {31'b0, e}, 1);
        check_vec("mis_rd_data", rd, 32'h0);
        check_vec("mis_rd_lat", lat, 3);

        xact(0, 1, 32'h13, 32'hFFFF0000, DLEN_HALF, lat, rd, e);
        check_vec("mis_hw_err", {31'b0, e}, 1);
        xact(1, 0, 32'h10, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("mis_hw_dropped", rd, 32'h1234BEEF);
        check_vec("good_rd_noerr", {31'b0, e}, 0);

        xact(1, 0, 32'h1000, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("oor_err", {31'b0, e}, 1);
        check_vec("oor_data", rd, 32'h0);

        xact(1, 0, 32'h10, 32'h0, DLEN_WORD, lat, rd, e);
        xact(1, 0, 32'h10, 32'h0, 3'd3, lat, rd, e);
        check_vec("dlen3_err", {31'b0, e}, 1);
        check_vec("dlen3_data", rd, 32'h0);

        xact(1, 1, 32'h10, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("rdwr_err", {31'b0, e}, 1);
        xact(1, 0, 32'h10, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("rdwr_dropped", rd, 32'h1234BEEF);

        // no request: das low, or no direction
        @(negedge clk);
        das = 1'b0; drd = 1'b1; daddr = 32'h10;
        #1 check_vec("nodas_hlt_c0", {31'b0, hlt_m}, 0);
        @(posedge clk); #1 check_vec("nodas_hlt_c1", {31'b0, hlt_m}, 0);
        @(negedge clk);
        das = 1'b1; drd = 1'b0; dwr = 1'b0;
        #1 check_vec("nodir_hlt", {31'b0, hlt_m}, 0);
        @(posedge clk); #1 check_vec("nodir_hlt_c1", {31'b0, hlt_m}, 0);
        das = 1'b0;

        // zero wait states, base 0x2000, 256 bytes
        sel = 1'b1;
        vals[0] = 32'h11111111; vals[1] = 32'h22222222;
        vals[2] = 32'h33333333; vals[3] = 32'hCAFEF00D;
        xact(0, 1, 32'h2000, vals[0], DLEN_WORD, lat, rd, e);
        check_vec("z_ww_lat", lat, 2);
        xact(0, 1, 32'h2004, vals[1], DLEN_WORD, lat, rd, e);
        xact(0, 1, 32'h2008, vals[2], DLEN_WORD, lat, rd, e);
        xact(0, 1, 32'h20FC, vals[3], DLEN_WORD, lat, rd, e);
        check_vec("z_top_err", {31'b0, e}, 0);
        for (int i = 0; i < 4; i++) begin
            xact(1, 0, (i == 3) ? 32'h20FC : 32'h2000 + 32'(4 * i), 32'h0, DLEN_WORD, lat, rd, e);
            starts[i] = start_cyc;
            check_vec($sformatf("z_rd%0d_lat", i), lat, 2);
            check_vec($sformatf("z_rd%0d_data", i), rd, vals[i]);
        end
        for (int i = 1; i < 4; i++)
            check_vec($sformatf("z_b2b_gap%0d", i), starts[i] - starts[i-1], 3);
        xact(1, 0, 32'h2100, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("z_oor_hi_err", {31'b0, e}, 1);
        check_vec("z_oor_hi_data", rd, 32'h0);
        xact(1, 0, 32'h2004, 32'h0, DLEN_WORD, lat, rd, e);
        xact(1, 0, 32'h1FFC, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("z_oor_lo_err", {31'b0, e}, 1);
        check_vec("z_oor_lo_data", rd, 32'h0);
        sel = 1'b0;

        // reset during WAIT
        @(negedge clk);
        das = 1'b1; dwr = 1'b1; drd = 1'b0; daddr = 32'h10; datao = 32'h0BADF00D; dlen = DLEN_WORD;
        #1 check_vec("rw_hlt_c0", {31'b0, hlt0}, 1);
        @(posedge clk);
        #1 check_vec("rw_in_wait", 32'(dut0.state_q), 32'(WAIT));
        #2 reset = 1'b0;
        #1;
        check_vec("rw_hlt_drop", {31'b0, hlt0}, 0);
        check_vec("rw_state_idle", 32'(dut0.state_q), 32'(IDLE));
        @(negedge clk);
        das = 1'b0; dwr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
`ifdef DMEM_ACCESS_COUNTERS_EN
        #1;
        check_vec("cnt_rst_rd", rdc0, 32'd0);
        check_vec("cnt_rst_wr", wrc0, 32'd0);
`endif
        xact(1, 0, 32'h10, 32'h0, DLEN_WORD, lat, rd, e);
        check_vec("rw_write_lost", rd, 32'h1234BEEF);

`ifdef DMEM_ACCESS_COUNTERS_EN
        xact(1, 0, 32'h10, 32'h0, DLEN_WORD, lat, rd, e);
        xact(0, 1, 32'h14, 32'h01020304, DLEN_WORD, lat, rd, e);
        xact(1, 0, 32'h14, 32'h0, DLEN_BYTE, lat, rd, e);
        xact(0, 1, 32'h18, 32'h0000BB00, DLEN_BYTE, lat, rd, e);
        xact(1, 0, 32'h15, 32'h0, DLEN_HALF, lat, rd, e);
        check_vec("cnt_fault_err", {31'b0, e}, 1);
        check_vec("cnt_rd", rdc0, 32'd3);
        check_vec("cnt_wr", wrc0, 32'd2);
        check_vec("cnt_other_rd", rdc1, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
